user_tlp_req_seq: RTL
=====================

USER_TLP_REQ_SEQ -- requirements
Module: user_tlp_req_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request FIFO entries; power of two, at least 2.
REQ-002 Parameter MAX_RD_OUTSTANDING, default 4, maximum non-posted reads in flight; range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, tx_done watchdog limit; used only with REQ_SEQ_TIMEOUT_EN.
REQ-004 Port user_clk, input, 1, single clock for all logic.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Ports req_valid/req_ready, input/output, 1/1, upstream request handshake.
REQ-007 Ports req_type[2:0], req_addr[63:0], req_data[31:0], input, request fields; types are 000 MemRd32, 001 MemWr32, 010 MemRd64, 011 MemWr64.
REQ-008 Ports tx_type[2:0], tx_tag[7:0], tx_addr[63:0], tx_data[31:0], output, fields to the TLP encoder.
REQ-009 Port tx_start, output, 1, one-cycle issue pulse to the encoder.
REQ-010 Port tx_done, input, 1, one-cycle completion pulse from the encoder.
REQ-011 Ports cpl_valid (input, 1) and cpl_tag[7:0] (input, 8), read-completion retire strobe from the completion path.
REQ-012 Ports rd_outstanding[7:0] (output, 8) and fifo_count[$clog2(FIFO_DEPTH):0] (output), status counts.
REQ-013 Ports err_bad_type (output, 1, pulse) and err_timeout (output, 1, sticky), error flags.

Function
REQ-014 req_ready SHALL equal !full; a push occurs when req_valid && req_ready.
REQ-015 A request with req_type[2]==1 SHALL be accepted but not stored, and SHALL pulse err_bad_type for exactly one cycle on the following cycle.
REQ-016 The FIFO SHALL be first-in first-out; a push and a pop in the same cycle SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 The FSM SHALL have three states: IDLE, START, and WAIT_DONE.
REQ-018 In IDLE, the head entry SHALL be issued when the FIFO is not empty and either the entry is a write or rd_outstanding < MAX_RD_OUTSTANDING; otherwise the FSM stays in IDLE.
REQ-019 On issue, the head SHALL be popped, latched into tx_type/tx_addr/tx_data with tx_tag = tag_ctr, and the FSM SHALL move to START.
REQ-020 In START, tx_start SHALL be 1 for exactly one cycle, then the FSM SHALL move to WAIT_DONE.
REQ-021 tx_type/tx_tag/tx_addr/tx_data SHALL remain stable from START through the cycle in which tx_done is sampled.
REQ-022 In WAIT_DONE, on tx_done the FSM SHALL return to IDLE; tx_done seen in any other state SHALL be ignored.
REQ-023 tag_ctr (8 bits) SHALL increment by 1 per issue and wrap from 255 to 0.
REQ-024 rd_outstanding SHALL increment on tx_done for a read (tx_type[0]==0) and decrement on cpl_valid; when both occur in the same cycle it SHALL be unchanged.
REQ-025 cpl_valid SHALL be ignored when rd_outstanding==0, with no underflow; cpl_tag is informational only.
REQ-026 Minimum issue spacing SHALL be one request per IDLE-START-WAIT_DONE round trip, i.e. 3 cycles plus encoder latency.

Reset
REQ-027 While reset_n==0: FSM=IDLE, FIFO empty, tag_ctr=0, rd_outstanding=0, tx_start=0, tx_type/tx_tag/tx_addr/tx_data=0, err_bad_type=0, err_timeout=0, and req_ready=0.
REQ-028 Reset assertion mid-transaction SHALL discard all queued and in-flight state; after deassertion, req_ready SHALL be 1 from the first clock.

Configuration
REQ-029 With macro REQ_SEQ_TIMEOUT_EN defined, a counter SHALL run in WAIT_DONE; on reaching TIMEOUT_CYCLES without tx_done, err_timeout SHALL set and hold until reset, and the FSM SHALL keep waiting (no abort).
REQ-030 Without REQ_SEQ_TIMEOUT_EN, no counter SHALL be built and err_timeout SHALL be tied to 0.

Verification
REQ-031 Single MemWr64 with addr 0x1000, data 0xDEADBEEF, and tx_done 3 cycles after tx_start -> one tx_start pulse, tx_tag=0, fields stable until tx_done, rd_outstanding stays 0.
REQ-032 Five MemRd32 requests with no cpl_valid and MAX_RD_OUTSTANDING=4 -> four issues with tags 0..3, fifth held; one cpl_valid -> fifth issues with tag 4.
REQ-033 Push with req_valid held and no tx_done -> fifo_count reaches 4 and req_ready=0; one tx_done -> one pop, and req_ready returns to 1.
REQ-034 req_type=3'b100 -> accepted, err_bad_type pulses once, fifo_count unchanged, no tx_start.
REQ-035 tx_done and cpl_valid in the same cycle with rd_outstanding=2 for a read -> rd_outstanding stays 2; 256 issues -> tag wraps to 0.
REQ-036 With REQ_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold tx_done -> err_timeout=1 after 16 WAIT_DONE cycles; reset_n pulse mid-WAIT_DONE -> all outputs return to REQ-027 values.

Source files
------------

// File: rtl/user_tlp_req_seq_if.sv
// ============================================================================
// Module      : user_tlp_req_seq_if
// Description : Request channel and TLP-encoder channel of the request sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface user_tlp_req_seq_if;
  // Upstream request handshake
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [63:0] req_addr;
  logic [31:0] req_data;
  // TLP encoder side
  logic [2:0]  tx_type;
  logic [7:0]  tx_tag;
  logic [63:0] tx_addr;
  logic [31:0] tx_data;
  logic        tx_start;
  logic        tx_done;

  // Environment: request source plus encoder
  modport master (
    output req_valid, req_type, req_addr, req_data, tx_done,
    input  req_ready, tx_type, tx_tag, tx_addr, tx_data, tx_start
  );

  // Sequencer
  modport slave (
    input  req_valid, req_type, req_addr, req_data, tx_done,
    output req_ready, tx_type, tx_tag, tx_addr, tx_data, tx_start
  );
endinterface

`default_nettype wire

// File: rtl/user_tlp_req_seq.sv
// ============================================================================
// Module      : user_tlp_req_seq
// Description : Queues user memory requests and issues them one at a time to a
//               TLP encoder, throttling non-posted reads by outstanding count.
//               Optional tx_done watchdog: define REQ_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module user_tlp_req_seq #(
  parameter int FIFO_DEPTH         = 4,
  parameter int MAX_RD_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  wire logic                      user_clk,
  input  wire logic                      reset_n,
  user_tlp_req_seq_if.slave              bus,
  input  wire logic                      cpl_valid,
  input  wire logic [7:0]                cpl_tag,
  output logic [7:0]                     rd_outstanding,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           err_bad_type,
  output logic                           err_timeout
);

  localparam int                 c_ptr_w    = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w    = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);
  localparam logic [7:0]         c_max_rd   = 8'(MAX_RD_OUTSTANDING);
  localparam logic [31:0]        c_to_vec   = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [63:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t               r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_ready_en;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_tag_ctr;
  logic [2:0]           r_tx_type;
  logic [7:0]           r_tx_tag;
  logic [63:0]          r_tx_addr;
  logic [31:0]          r_tx_data;
  logic [7:0]           r_rd_out;
  logic                 r_err_bad_type;

  entry_t               w_new;
  entry_t               w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_store;
  logic                 w_issue;
  logic                 w_tx_start;
  logic                 w_rd_inc;
  logic                 w_rd_dec;
  logic                 w_unused;

  // Ready is held low through reset and rises on the first clock after release.
  assign w_full        = (r_count == c_full_cnt);
  assign w_empty       = (r_count == '0);
  assign bus.req_ready = r_ready_en && !w_full;
  assign w_push        = bus.req_valid && bus.req_ready;
  assign w_store       = w_push && !bus.req_type[2];
  assign w_new         = '{typ: bus.req_type, addr: bus.req_addr, data: bus.req_data};
  assign w_head        = r_mem[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_tx_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Writes are posted and never throttled; reads wait for credit.
        if (!w_empty && (w_head.typ[0] || (r_rd_out < c_max_rd))) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_tx_start  = 1'b1;
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge user_clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_ready_en     <= 1'b0;
      r_err_bad_type <= 1'b0;
    end else begin
      r_ready_en     <= 1'b1;
      r_err_bad_type <= w_push && bus.req_type[2];
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_store, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_ctr <= 8'd0;
      r_tx_type <= 3'd0;
      r_tx_tag  <= 8'd0;
      r_tx_addr <= 64'd0;
      r_tx_data <= 32'd0;
    end else if (w_issue) begin
      r_tag_ctr <= r_tag_ctr + 8'd1;
      r_tx_type <= w_head.typ;
      r_tx_tag  <= r_tag_ctr;
      r_tx_addr <= w_head.addr;
      r_tx_data <= w_head.data;
    end
  end

  // A read counts as outstanding once the encoder has sent it.
  assign w_rd_inc = (r_state == ST_WAIT_DONE) && bus.tx_done && !r_tx_type[0];
  assign w_rd_dec = cpl_valid && (r_rd_out != 8'd0);

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_out <= 8'd0;
    end else begin
      case ({w_rd_inc, w_rd_dec})
        2'b10:   r_rd_out <= r_rd_out + 8'd1;
        2'b01:   r_rd_out <= r_rd_out - 8'd1;
        default: r_rd_out <= r_rd_out;
      endcase
    end
  end

`ifdef REQ_SEQ_TIMEOUT_EN
  localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_err_timeout;

  // Counting stops once the flag is set; the FSM keeps waiting regardless.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else if (r_state != ST_WAIT_DONE) begin
      r_to_cnt <= '0;
    end else if (!bus.tx_done && !r_err_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt == c_to_last) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

  assign w_unused       = ^{cpl_tag, c_to_vec};

  assign bus.tx_type    = r_tx_type;
  assign bus.tx_tag     = r_tx_tag;
  assign bus.tx_addr    = r_tx_addr;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_start   = w_tx_start;
  assign rd_outstanding = r_rd_out;
  assign fifo_count     = r_count;
  assign err_bad_type   = r_err_bad_type;

endmodule

`default_nettype wire
